// File: rtl/sdpram_bist_pkg.sv
// rtl/sdpram_bist_pkg.sv - state codes, pattern codes and checkerboard helper for the SDPRAM BIST
package sdpram_bist_pkg;

  localparam int CB_MAX = 1152;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_WRITE = 3'd1;
  localparam state_t ST_GAP   = 3'd2;
  localparam state_t ST_READ  = 3'd3;
  localparam state_t ST_DRAIN = 3'd4;
  localparam state_t ST_DONE  = 3'd5;

  localparam logic [1:0] PAT_DOWN     = 2'd0;
  localparam logic [1:0] PAT_CHECKER  = 2'd1;
  localparam logic [1:0] PAT_ADDR     = 2'd2;
  localparam logic [1:0] PAT_INV_DOWN = 2'd3;

  // Even-index checkerboard word: MSB is 1, bits alternate 1010.. down to bit 0.
  function automatic logic [CB_MAX-1:0] cb_word(input int width);
    logic [CB_MAX-1:0] w;
    w = '0;
    for (int j = 0; j < CB_MAX; j++) begin
      if (j < width) w[j] = (((width - 1 - j) % 2) == 0);
    end
    return w;
  endfunction

endpackage

// File: rtl/sdpram_bist_pattern_gen.sv
// rtl/sdpram_bist_pattern_gen.sv - maps (pattern, address index) to the BIST data word
module sdpram_bist_pattern_gen
  import sdpram_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 24
) (
  input  logic [1:0]            pattern_i,
  input  logic [ADDR_WIDTH-1:0] index_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  localparam logic [CB_MAX-1:0]     CB_FULL = cb_word(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] CB_EVEN = CB_FULL[DATA_WIDTH-1:0];

  logic [DATA_WIDTH-1:0] idx_ext;
  logic [DATA_WIDTH-1:0] down;

  always_comb begin
    idx_ext = DATA_WIDTH'(index_i);
    down    = {DATA_WIDTH{1'b1}} - idx_ext;
    case (pattern_i)
      PAT_DOWN:    data_o = down;
      PAT_CHECKER: data_o = index_i[0] ? ~CB_EVEN : CB_EVEN;
      PAT_ADDR:    data_o = idx_ext;
      default:     data_o = ~down;
    endcase
  end

endmodule

// File: rtl/sdpram_bist_ctrl.sv
// rtl/sdpram_bist_ctrl.sv - write/read-compare BIST controller for an external SDPRAM
// Define SDPRAM_BIST_FIRST_ERR_EN to build the first-mismatch address capture register.
module sdpram_bist_ctrl
  import sdpram_bist_pkg::*;
#(
  parameter int ADDR_WIDTH    = 11,
  parameter int DATA_WIDTH    = 24,
  parameter int RD_LATENCY    = 1,
  parameter int ERR_CNT_WIDTH = 3
) (
  input  logic                     wr_clk,
  input  logic                     tb_wr_rst,
  input  logic                     start,
  input  logic [1:0]               pattern,
  output logic                     ram_wr_en,
  output logic [ADDR_WIDTH-1:0]    ram_wr_addr,
  output logic [DATA_WIDTH-1:0]    ram_wr_data,
  output logic                     ram_rd_en,
  output logic [ADDR_WIDTH-1:0]    ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]    ram_rd_data,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt,
  output logic [ADDR_WIDTH-1:0]    first_err_addr
);

  state_t                   state_q, state_d;
  logic [ADDR_WIDTH:0]      addr_q, addr_d, addr_inc;
  logic [1:0]               drain_q, drain_d;
  logic [1:0]               pat_q, pat_d;
  logic [ERR_CNT_WIDTH-1:0] err_q, err_d;
  logic [RD_LATENCY-1:0]    vld_q;
  logic [ADDR_WIDTH-1:0]    raddr_q [RD_LATENCY];
  logic                     accept, in_write, in_read, mismatch;
  logic [DATA_WIDTH-1:0]    wr_pat, exp_data;

  assign accept   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign in_write = (state_q == ST_WRITE);
  assign in_read  = (state_q == ST_READ);
  // The spare top bit of the counter flags the pass over the last address.
  assign addr_inc = addr_q + (ADDR_WIDTH+1)'(1);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    drain_d = drain_q;
    pat_d   = pat_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_WRITE;
          addr_d  = '0;
          pat_d   = pattern;
        end
      end
      ST_WRITE: begin
        addr_d = addr_inc;
        if (addr_inc[ADDR_WIDTH]) begin
          state_d = ST_GAP;
          addr_d  = '0;
        end
      end
      ST_GAP: state_d = ST_READ;
      ST_READ: begin
        addr_d = addr_inc;
        if (addr_inc[ADDR_WIDTH]) begin
          state_d = ST_DRAIN;
          addr_d  = '0;
          drain_d = '0;
        end
      end
      ST_DRAIN: begin
        if (drain_q == 2'(RD_LATENCY - 1)) state_d = ST_DONE;
        else                               drain_d = drain_q + 2'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mismatch = vld_q[RD_LATENCY-1] && (ram_rd_data != exp_data);

  always_comb begin
    err_d = err_q;
    if (accept)                                   err_d = '0;
    else if (mismatch && (err_q != '1))           err_d = err_q + ERR_CNT_WIDTH'(1);
  end

  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      drain_q <= '0;
      pat_q   <= '0;
      err_q   <= '0;
      vld_q   <= '0;
      for (int i = 0; i < RD_LATENCY; i++) raddr_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      drain_q    <= drain_d;
      pat_q      <= pat_d;
      err_q      <= err_d;
      vld_q[0]   <= in_read;
      raddr_q[0] <= addr_q[ADDR_WIDTH-1:0];
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i]   <= vld_q[i-1];
        raddr_q[i] <= raddr_q[i-1];
      end
    end
  end

  sdpram_bist_pattern_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_wr_gen (
    .pattern_i(pat_q),
    .index_i  (addr_q[ADDR_WIDTH-1:0]),
    .data_o   (wr_pat)
  );

  sdpram_bist_pattern_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_exp_gen (
    .pattern_i(pat_q),
    .index_i  (raddr_q[RD_LATENCY-1]),
    .data_o   (exp_data)
  );

`ifdef SDPRAM_BIST_FIRST_ERR_EN
  logic [ADDR_WIDTH-1:0] first_err_q;

  // A zero error count means no mismatch has been seen yet in this run.
  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst)                     first_err_q <= '0;
    else if (accept)                   first_err_q <= '0;
    else if (mismatch && (err_q == '0)) first_err_q <= raddr_q[RD_LATENCY-1];
  end

  assign first_err_addr = first_err_q;
`else
  assign first_err_addr = '0;
`endif

  assign ram_wr_en   = in_write;
  assign ram_wr_addr = in_write ? addr_q[ADDR_WIDTH-1:0] : '0;
  assign ram_wr_data = in_write ? wr_pat : '0;
  assign ram_rd_en   = in_read;
  assign ram_rd_addr = in_read ? addr_q[ADDR_WIDTH-1:0] : '0;
  assign busy        = in_write || in_read || (state_q == ST_GAP) || (state_q == ST_DRAIN);
  assign done        = (state_q == ST_DONE);
  assign pass        = done && (err_q == '0);
  assign err_cnt     = err_q;

endmodule

// File: tb/tb_sdpram_bist_ctrl.sv
// tb/tb_sdpram_bist_ctrl.sv - randomized self-checking bench for sdpram_bist_ctrl with a behavioural reference
module tb_sdpram_bist_ctrl;

  localparam int AW = 9;
  localparam int N  = 512;

  logic wr_clk    = 1'b0;
  logic tb_wr_rst = 1'b1;
  always #5 wr_clk = ~wr_clk;

  logic        start1 = 1'b0, start2 = 1'b0;
  logic [1:0]  pattern1 = '0, pattern2 = '0;
  logic        ram_wr_en1, ram_rd_en1, busy1, done1, pass1;
  logic        ram_wr_en2, ram_rd_en2, busy2, done2, pass2;
  logic [AW-1:0] ram_wr_addr1, ram_rd_addr1, first_err_addr1;
  logic [AW-1:0] ram_wr_addr2, ram_rd_addr2, first_err_addr2;
  logic [23:0] ram_wr_data1, ram_rd_data1;
  logic [7:0]  ram_wr_data2, ram_rd_data2;
  logic [2:0]  err_cnt1, err_cnt2;

  sdpram_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(24), .RD_LATENCY(1), .ERR_CNT_WIDTH(3)) u_dut1 (
    .wr_clk(wr_clk), .tb_wr_rst(tb_wr_rst), .start(start1), .pattern(pattern1),
    .ram_wr_en(ram_wr_en1), .ram_wr_addr(ram_wr_addr1), .ram_wr_data(ram_wr_data1),
    .ram_rd_en(ram_rd_en1), .ram_rd_addr(ram_rd_addr1), .ram_rd_data(ram_rd_data1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err_cnt1), .first_err_addr(first_err_addr1)
  );

  sdpram_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(8), .RD_LATENCY(2), .ERR_CNT_WIDTH(3)) u_dut2 (
    .wr_clk(wr_clk), .tb_wr_rst(tb_wr_rst), .start(start2), .pattern(pattern2),
    .ram_wr_en(ram_wr_en2), .ram_wr_addr(ram_wr_addr2), .ram_wr_data(ram_wr_data2),
    .ram_rd_en(ram_rd_en2), .ram_rd_addr(ram_rd_addr2), .ram_rd_data(ram_rd_data2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err_cnt2), .first_err_addr(first_err_addr2)
  );

  // External RAM models: dut1 has a 1-cycle RAM with optional bit-0 stuck-at-1,
  // dut2 has a RAM whose latency can be 2 (matching) or 1 (mismatched).
  logic        stuck1 = 1'b0;
  int          lat2   = 2;
  logic [23:0] mem1 [N];
  logic [7:0]  mem2 [N];
  logic [23:0] r1a;
  logic [7:0]  r2a, r2b;

  always @(posedge wr_clk) begin
    if (ram_wr_en1) mem1[ram_wr_addr1] <= ram_wr_data1;
    if (ram_rd_en1) r1a <= mem1[ram_rd_addr1] | {23'd0, stuck1};
    if (ram_wr_en2) mem2[ram_wr_addr2] <= ram_wr_data2;
    if (ram_rd_en2) r2a <= mem2[ram_rd_addr2];
    r2b <= r2a;
  end

  assign ram_rd_data1 = r1a;
  assign ram_rd_data2 = (lat2 == 2) ? r2b : r2a;

  int sel = 0;
  logic          busy_s, done_s, pass_s, wr_en_s, rd_en_s;
  logic [2:0]    err_s;
  logic [AW-1:0] fe_s, wr_addr_s, rd_addr_s;
  logic [23:0]   wr_data_s;

  always_comb begin
    busy_s    = (sel != 0) ? busy2 : busy1;
    done_s    = (sel != 0) ? done2 : done1;
    pass_s    = (sel != 0) ? pass2 : pass1;
    err_s     = (sel != 0) ? err_cnt2 : err_cnt1;
    fe_s      = (sel != 0) ? first_err_addr2 : first_err_addr1;
    wr_en_s   = (sel != 0) ? ram_wr_en2 : ram_wr_en1;
    rd_en_s   = (sel != 0) ? ram_rd_en2 : ram_rd_en1;
    wr_addr_s = (sel != 0) ? ram_wr_addr2 : ram_wr_addr1;
    rd_addr_s = (sel != 0) ? ram_rd_addr2 : ram_rd_addr1;
    wr_data_s = (sel != 0) ? {16'd0, ram_wr_data2} : ram_wr_data1;
  end

  logic [63:0] wlog [N];
  int wcnt, rcnt, quiet, order_bad, wnext, rnext;

  always @(negedge wr_clk) begin
    if (wr_en_s) begin
      wlog[wr_addr_s] = 64'(wr_data_s);
      if (int'(wr_addr_s) != wnext) order_bad++;
      wnext++;
      wcnt++;
    end
    if (rd_en_s) begin
      if (int'(rd_addr_s) != rnext) order_bad++;
      rnext++;
      rcnt++;
    end
    if (busy_s && !wr_en_s && !rd_en_s) quiet++;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_data(input int pat, input int i, input int dw);
    logic [63:0] mask, down, cb;
    mask = (64'd1 << dw) - 64'd1;
    down = (mask - 64'(i)) & mask;
    cb   = 64'hAAAA_AAAA_AAAA_AAAA >> (64 - dw);
    case (pat)
      0:       return down;
      1:       return ((i % 2) == 0) ? cb : (~cb & mask);
      2:       return 64'(i) & mask;
      default: return ~down & mask;
    endcase
  endfunction

  // Predict the saturated error count and first failing index from what the RAM will hand back.
  task automatic model_run(input int pat, input int dw, input bit stuck, input bit lat_short,
                           output int exp_err, output int exp_first);
    int errs;
    logic [63:0] got;
    errs      = 0;
    exp_first = 0;
    for (int i = 0; i < N; i++) begin
      if (lat_short) got = ref_data(pat, (i < N - 1) ? i + 1 : N - 1, dw);
      else           got = ref_data(pat, i, dw) | 64'(stuck);
      if (got != ref_data(pat, i, dw)) begin
        if (errs == 0) exp_first = i;
        errs++;
      end
    end
    exp_err = (errs > 7) ? 7 : errs;
  endtask

  task automatic set_start(input bit v);
    if (sel == 0) start1 = v;
    else          start2 = v;
  endtask

  task automatic set_pat(input int p);
    if (sel == 0) pattern1 = 2'(p);
    else          pattern2 = 2'(p);
  endtask

  task automatic run(input int which, input int pat, input bit stuck, input bit lat_short, input int repulse_at);
    int cnt, exp_err, exp_first, bad, rl, dw;
    sel = which;
    rl  = (which != 0) ? 2 : 1;
    dw  = (which != 0) ? 8 : 24;
    if (which == 0) stuck1 = stuck;
    else            lat2   = lat_short ? 1 : 2;
    model_run(pat, dw, stuck, lat_short, exp_err, exp_first);
`ifndef SDPRAM_BIST_FIRST_ERR_EN
    exp_first = 0;
`endif
    wcnt = 0; rcnt = 0; quiet = 0; order_bad = 0; wnext = 0; rnext = 0;
    set_pat(pat);
    set_start(1'b1);
    @(negedge wr_clk);
    set_start(1'b0);
    set_pat(int'($urandom_range(0, 3)));
    cnt = 0;
    while (busy_s && cnt < 5000) begin
      cnt++;
      set_start(cnt == repulse_at);
      if (cnt == repulse_at) set_pat(int'($urandom_range(0, 3)));
      @(negedge wr_clk);
    end
    set_start(1'b0);
    check_eq("timeout", 64'(cnt < 5000), 64'd1);
    check_eq("run_len", 64'(cnt), 64'(2 * N + 1 + rl));
    check_eq("done", 64'(done_s), 64'd1);
    check_eq("pass", 64'(pass_s), 64'(exp_err == 0));
    check_eq("err_cnt", 64'(err_s), 64'(exp_err));
    check_eq("first_err_addr", 64'(fe_s), 64'(exp_first));
    check_eq("wr_count", 64'(wcnt), 64'(N));
    check_eq("rd_count", 64'(rcnt), 64'(N));
    check_eq("idle_busy_cycles", 64'(quiet), 64'(1 + rl));
    check_eq("addr_order", 64'(order_bad), 64'd0);
    bad = 0;
    for (int i = 0; i < N; i++) if (wlog[i] !== ref_data(pat, i, dw)) bad++;
    check_eq("wr_data", 64'(bad), 64'd0);
    @(negedge wr_clk);
    check_eq("done_hold", {62'd0, done_s, busy_s}, 64'd2);
  endtask

  initial begin
    int cnt;
    tb_wr_rst = 1'b1;
    repeat (3) @(negedge wr_clk);
    check_eq("rst_d1_outs", 64'({ram_wr_en1, ram_rd_en1, ram_wr_addr1, ram_rd_addr1, ram_wr_data1,
                                 busy1, done1, pass1, err_cnt1, first_err_addr1}), 64'd0);
    check_eq("rst_d2_outs", 64'({ram_wr_en2, ram_rd_en2, ram_wr_addr2, ram_rd_addr2, ram_wr_data2,
                                 busy2, done2, pass2, err_cnt2, first_err_addr2}), 64'd0);
    tb_wr_rst = 1'b0;
    @(negedge wr_clk);
    check_eq("idle_after_rst", 64'({busy1, done1, busy2, done2}), 64'd0);

    run(0, 0, 1'b0, 1'b0, 0);
    check_eq("d1_addr0", wlog[0], 64'hFF_FFFF);
    check_eq("d1_addr511", wlog[511], 64'hFF_FE00);
    for (int k = 0; k < 3; k++)
      run(0, int'($urandom_range(0, 3)), 1'b0, 1'b0, int'($urandom_range(1, 2 * N + 1)));
    run(0, 0, 1'b1, 1'b0, 0);
    run(0, int'($urandom_range(0, 3)), 1'b0, 1'b0, 2 * N + 2);

    run(1, 1, 1'b0, 1'b0, 0);
    run(1, 1, 1'b0, 1'b1, 0);
    run(1, 2, 1'b0, 1'b0, 0);
    check_eq("d2_addr300", wlog[300], 64'h2C);
    run(1, int'($urandom_range(0, 3)), 1'b0, 1'b0, int'($urandom_range(1, 2 * N + 2)));

    sel = 0;
    stuck1 = 1'b0;
    pattern1 = 2'(int'($urandom_range(0, 3)));
    start1 = 1'b1;
    @(negedge wr_clk);
    start1 = 1'b0;
    cnt = 0;
    while (!ram_rd_en1 && cnt < 2000) begin
      @(negedge wr_clk);
      cnt++;
    end
    repeat (int'($urandom_range(1, 400))) @(negedge wr_clk);
    check_eq("mid_read", 64'(ram_rd_en1), 64'd1);
    tb_wr_rst = 1'b1;
    #1;
    check_eq("rst_mid_outs", 64'({ram_wr_en1, ram_rd_en1, ram_wr_addr1, ram_rd_addr1, ram_wr_data1,
                                  busy1, done1, pass1, err_cnt1, first_err_addr1}), 64'd0);
    @(negedge wr_clk);
    tb_wr_rst = 1'b0;
    @(negedge wr_clk);
    run(0, int'($urandom_range(0, 3)), 1'b0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
